// File: rtl/trig_clk_pkg.sv
// Shared definitions for the MMCM fine phase-shift controller: state encoding and default sizing.
package trig_clk_pkg;

  localparam int STEP_WIDTH_DEF     = 16;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/trig_clk_ps_watchdog.sv
// psdone watchdog: counts cycles since the last psen and flags when the MMCM never answered.
module trig_clk_ps_watchdog
  import trig_clk_pkg::*;
#(
  parameter int pTIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic usb_clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(pTIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(pTIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The ISSUE cycle counts as elapsed cycle 1, so the state is IDLE exactly
  // pTIMEOUT_CYCLES cycles after psen.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_W'(1);
    end else if (run && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/trig_clk_phase_ctrl.sv
// Steps the MMCM fine phase shift one psen at a time until the applied offset reaches the target.
// Optional psdone watchdog is compiled in when TRIG_CLK_PS_TIMEOUT_EN is defined.
module trig_clk_phase_ctrl
  import trig_clk_pkg::*;
#(
  parameter int pSTEP_WIDTH     = STEP_WIDTH_DEF,
  parameter int pTIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   usb_clk,
  input  logic                   reset,
  input  logic [pSTEP_WIDTH-1:0] I_target,
  input  logic                   I_go,
  input  logic                   I_abort,
  input  logic                   I_locked,
  input  logic                   I_psdone,
  input  logic                   I_clear_error,
  output logic                   O_psen,
  output logic                   O_psincdec,
  output logic [pSTEP_WIDTH-1:0] O_current,
  output logic                   O_busy,
  output logic                   O_error
);

  state_e state_q, state_d;
  logic signed [pSTEP_WIDTH-1:0] target_q, target_d;
  logic signed [pSTEP_WIDTH-1:0] current_q, current_d;
  logic signed [pSTEP_WIDTH-1:0] tgt_in;
  logic psincdec_q, psincdec_d;
  logic abort_q, abort_d;
  logic error_q, error_d;
  logic err_set;
  logic go_eff;
  logic wd_expire;

  function automatic logic step_up(input logic signed [pSTEP_WIDTH-1:0] tgt,
                                   input logic signed [pSTEP_WIDTH-1:0] cur);
    return tgt > cur;
  endfunction

  // Two's-complement wrap at pSTEP_WIDTH is intentional.
  function automatic logic signed [pSTEP_WIDTH-1:0] step_next(
      input logic signed [pSTEP_WIDTH-1:0] cur, input logic up);
    return up ? cur + pSTEP_WIDTH'(1) : cur - pSTEP_WIDTH'(1);
  endfunction

  assign tgt_in = I_target;
  assign go_eff = I_go && !I_abort;

`ifdef TRIG_CLK_PS_TIMEOUT_EN
  trig_clk_ps_watchdog #(
    .pTIMEOUT_CYCLES(pTIMEOUT_CYCLES)
  ) u_watchdog (
    .usb_clk(usb_clk),
    .reset  (reset),
    .clr    (state_q == ST_ISSUE),
    .run    (state_q == ST_WAIT),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    current_d  = current_q;
    psincdec_d = psincdec_q;
    abort_d    = abort_q;
    err_set    = 1'b0;

    if (go_eff) begin
      target_d = tgt_in;
    end

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (go_eff) begin
          if (!I_locked) begin
            err_set = 1'b1;
          end else if (tgt_in != current_q) begin
            state_d    = ST_ISSUE;
            psincdec_d = step_up(tgt_in, current_q);
          end
        end
      end
      ST_ISSUE: begin
        if (!I_locked) begin
          state_d = ST_IDLE;
          abort_d = 1'b0;
          err_set = 1'b1;
        end else begin
          state_d = ST_WAIT;
          if (I_abort) abort_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // Lock loss outranks a coincident psdone: the step is treated as lost.
        if (!I_locked) begin
          state_d = ST_IDLE;
          abort_d = 1'b0;
          err_set = 1'b1;
        end else if (I_psdone) begin
          current_d = step_next(current_q, psincdec_q);
          if (abort_q || I_abort || (current_d == target_d)) begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
          end else begin
            state_d    = ST_ISSUE;
            psincdec_d = step_up(target_d, current_d);
          end
        end else if (wd_expire) begin
          state_d = ST_IDLE;
          abort_d = 1'b0;
          err_set = 1'b1;
        end else if (I_abort) begin
          abort_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
      end
    endcase

    if (err_set) begin
      error_d = 1'b1;
    end else if (I_clear_error) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      current_q  <= '0;
      psincdec_q <= 1'b0;
      abort_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      current_q  <= current_d;
      psincdec_q <= psincdec_d;
      abort_q    <= abort_d;
      error_q    <= error_d;
    end
  end

  assign O_psen     = (state_q == ST_ISSUE);
  assign O_psincdec = psincdec_q;
  assign O_current  = current_q;
  assign O_busy     = (state_q != ST_IDLE);
  assign O_error    = error_q;

endmodule
